// File: rtl/conv_col_stream_engine.sv
// Column-streaming KxK convolution engine with a K-column sliding window.
// Ports: clk/rst; start, reuse_kernel, relu_en job control;
//   kernel_valid/kernel_data coefficient load (K*K weights then bias);
//   in_valid/in_ready/in_data multi-lane column beats;
//   out_valid/out_ready/out_data/out_col one output column per handshake;
//   busy while a job runs, done one-cycle pulse at job end.
module conv_col_stream_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 1,
    parameter int LANES       = 16,
    parameter int ACC_WIDTH   = 40,
    localparam int BEATS    = (IMAGE_SIZE + LANES - 1) / LANES,
    localparam int OUT_SIZE = (IMAGE_SIZE - KERNEL_SIZE) / STRIDE + 1,
    localparam int CW       = $clog2(IMAGE_SIZE) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                reuse_kernel,
    input  logic                                relu_en,
    input  logic                                kernel_valid,
    input  logic [DATA_WIDTH-1:0]               kernel_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_SIZE-1:0][DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]                       out_col,
    output logic                                busy,
    output logic                                done
);

    localparam int K  = KERNEL_SIZE;
    localparam int N  = IMAGE_SIZE;
    localparam int KK = K * K;
    localparam int KW = $clog2(KK + 1);
    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        LOAD_KERNEL,
        STREAM,
        FINISH
    } state_t;

    state_t state;

    logic [KW-1:0] k_idx;
    logic [BW-1:0] beat;
    logic [CW-1:0] col;
    logic          relu_q;

    logic signed [DATA_WIDTH-1:0] wgt [KK];
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [DATA_WIDTH-1:0] win [K][N];
    logic signed [DATA_WIDTH-1:0] colbuf [N];

    logic signed [DATA_WIDTH-1:0] new_col [N];
    logic signed [DATA_WIDTH-1:0] win_nxt [K][N];
    logic [OUT_SIZE-1:0][DATA_WIDTH-1:0] conv_res;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sh;
    logic signed [PW-1:0]        prod;

    logic in_hs;
    logic last_beat;
    logic out_hs;
    logic qual;
    int   col_i;
    int   oc_i;

    assign busy      = (state != IDLE);
    assign in_ready  = (state == STREAM) && (!out_valid || out_ready);
    assign in_hs     = in_ready && in_valid;
    assign last_beat = in_hs && (beat == BW'(BEATS - 1));
    assign out_hs    = out_valid && out_ready;

    assign col_i = int'(col);
    assign oc_i  = (col_i - (K - 1)) / STRIDE;
    assign qual  = (col_i >= K - 1) &&
                   (((col_i - (K - 1)) % STRIDE) == 0);

    // Column being completed: earlier beats come from colbuf, the final
    // beat's rows straight from the input lanes.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            if (BW'(r / LANES) == BW'(BEATS - 1))
                new_col[r] = in_data[(r % LANES)*DATA_WIDTH +: DATA_WIDTH];
            else
                new_col[r] = colbuf[r];
        end
    end

    always_comb begin
        for (int j = 0; j < K - 1; j++)
            win_nxt[j] = win[j + 1];
        win_nxt[K-1] = new_col;
    end

    // Full output column from the window as it will be after this beat.
    always_comb begin
        conv_res = '0;
        acc      = '0;
        sh       = '0;
        prod     = '0;
        for (int r = 0; r < OUT_SIZE; r++) begin
            acc = ACC_WIDTH'(bias) <<< FRAC_BITS;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    prod = PW'(wgt[i*K + j]) *
                           PW'(win_nxt[j][r*STRIDE + i]);
                    acc  = acc + ACC_WIDTH'(prod);
                end
            end
            sh = acc >>> FRAC_BITS;
            if (relu_q && sh < 0)
                sh = '0;
            if (sh > SAT_MAX)
                conv_res[r] = SAT_MAX[DATA_WIDTH-1:0];
            else if (sh < SAT_MIN)
                conv_res[r] = SAT_MIN[DATA_WIDTH-1:0];
            else
                conv_res[r] = sh[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k_idx     <= '0;
            beat      <= '0;
            col       <= '0;
            relu_q    <= 1'b0;
            bias      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            done      <= 1'b0;
            for (int i = 0; i < KK; i++)
                wgt[i] <= '0;
            for (int r = 0; r < N; r++) begin
                colbuf[r] <= '0;
                for (int j = 0; j < K; j++)
                    win[j][r] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        k_idx  <= '0;
                        beat   <= '0;
                        col    <= '0;
                        relu_q <= relu_en;
                        state  <= reuse_kernel ? STREAM : LOAD_KERNEL;
                    end
                end
                LOAD_KERNEL: begin
                    if (kernel_valid) begin
                        if (k_idx == KW'(KK)) begin
                            bias  <= kernel_data;
                            state <= STREAM;
                        end else begin
                            for (int i = 0; i < KK; i++)
                                if (k_idx == KW'(i))
                                    wgt[i] <= kernel_data;
                            k_idx <= k_idx + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (out_hs)
                        out_valid <= 1'b0;
                    if (in_hs) begin
                        for (int r = 0; r < N; r++)
                            if (BW'(r / LANES) == beat)
                                colbuf[r] <= in_data[(r % LANES)*DATA_WIDTH +:
                                                     DATA_WIDTH];
                        if (last_beat) begin
                            win  <= win_nxt;
                            beat <= '0;
                            col  <= col + 1'b1;
                            // A new column may replace an accepted one
                            // in the same cycle without a bubble.
                            if (qual) begin
                                out_valid <= 1'b1;
                                out_data  <= conv_res;
                                out_col   <= CW'(oc_i);
                            end
                            if (col == CW'(N - 1))
                                state <= FINISH;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_col_stream_engine.sv
// Self-checking bench for conv_col_stream_engine (stride 1 and stride 2).
// Ports: none; drives both engines and compares against a direct model.
module tb_conv_col_stream_engine;

    localparam int DW  = 16;
    localparam int N   = 28;
    localparam int K   = 5;
    localparam int L   = 16;
    localparam int B   = 2;
    localparam int OS  = 24;
    localparam int OS2 = 12;
    localparam int CW  = 6;

    logic clk = 0;
    logic rst = 1;
    logic start = 0;
    logic reuse_kernel = 0;
    logic relu_en = 0;
    logic kernel_valid = 0;
    logic [DW-1:0] kernel_data = '0;
    logic in_valid = 0;
    logic in_ready;
    logic [L*DW-1:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1;
    logic [OS-1:0][DW-1:0] out_data;
    logic [CW-1:0] out_col;
    logic busy, done;

    logic in_valid2;
    logic in_ready2;
    logic out_valid2;
    logic out_ready2 = 1;
    logic [OS2-1:0][DW-1:0] out_data2;
    logic [CW-1:0] out_col2;
    logic busy2, done2;

    always #5 clk = ~clk;

    conv_col_stream_engine #(.STRIDE(1)) u0 (
        .clk(clk), .rst(rst), .start(start),
        .reuse_kernel(reuse_kernel), .relu_en(relu_en),
        .kernel_valid(kernel_valid), .kernel_data(kernel_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col),
        .busy(busy), .done(done)
    );

    // Second engine only sees beats the first one accepts.
    assign in_valid2 = in_valid & in_ready;

    conv_col_stream_engine #(.STRIDE(2)) u1 (
        .clk(clk), .rst(rst), .start(start),
        .reuse_kernel(reuse_kernel), .relu_en(relu_en),
        .kernel_valid(kernel_valid), .kernel_data(kernel_data),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .out_col(out_col2),
        .busy(busy2), .done(done2)
    );

    int n_pass = 0;
    int n_total = 0;

    logic signed [DW-1:0] img [N][N];
    logic signed [DW-1:0] w_m [K*K];
    logic signed [DW-1:0] b_m;
    logic relu_m;

    logic [CW-1:0] q_col [$];
    logic [OS*DW-1:0] q_dat [$];
    logic [CW-1:0] q2_col [$];
    logic [OS*DW-1:0] q2_dat [$];
    int cyc = 0;
    int last_hs = -1;
    int done_cnt = 0;
    int done_cyc = -1;

    logic bp_rand = 0;
    logic hold_arm = 0;
    logic hold_seen = 0;

    task automatic chk(input string tag, input logic [OS*DW-1:0] got,
                       input logic [OS*DW-1:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Direct evaluation of the convolution formula for one output column.
    function automatic logic [OS*DW-1:0] model_col(int oc, int s, int os);
        logic [OS*DW-1:0] res = '0;
        longint acc;
        for (int r = 0; r < os; r++) begin
            acc = longint'(b_m) * 256;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    acc += longint'(w_m[i*K+j]) *
                           longint'(img[r*s+i][oc*s+j]);
            acc = acc >>> 8;
            if (relu_m && acc < 0) acc = 0;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            res[r*DW +: DW] = 16'(acc);
        end
        return res;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (out_valid && out_ready) begin
            q_col.push_back(out_col);
            q_dat.push_back(out_data);
            last_hs = cyc;
        end
        if (out_valid2 && out_ready2) begin
            q2_col.push_back(out_col2);
            q2_dat.push_back({{((OS-OS2)*DW){1'b0}}, out_data2});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        if (hold_arm && out_valid && out_col == 3) begin
            logic [OS*DW-1:0] hd;
            logic [CW-1:0] hc;
            hd = out_data;
            hc = out_col;
            out_ready = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("hold_data", out_data, hd);
                chk("hold_col", out_col, hc);
                chk("hold_inrdy", in_ready, 1'b0);
                @(posedge clk);
                #1;
            end
            hold_arm = 0;
            hold_seen = 1;
            out_ready = 1;
        end else begin
            out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_identity();
        for (int k = 0; k < K*K; k++) w_m[k] = '0;
        w_m[12] = 16'h0100;
        b_m = '0;
    endtask

    task automatic img_ramp();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = 16'(r + 32*c);
    endtask

    task automatic img_rand();
        int v;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                v = $urandom_range(0, 16383) - 8192;
                img[r][c] = 16'(v);
            end
    endtask

    task automatic img_const(input logic [DW-1:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                img[r][c] = v;
    endtask

    task automatic start_job(input logic reuse, input logic relu);
        start = 1;
        reuse_kernel = reuse;
        relu_en = relu;
        relu_m = relu;
        tick();
        start = 0;
        if (!reuse) begin
            for (int k = 0; k <= K*K; k++) begin
                kernel_valid = 1;
                kernel_data = (k < K*K) ? w_m[k] : b_m;
                tick();
                kernel_valid = 0;
                if ($urandom_range(0, 2) == 0) tick();
            end
        end
    endtask

    // Streams columns 0..stop_col-1; kernel noise toggles kernel_valid.
    task automatic stream(input int stop_col, input logic noise);
        int n;
        int row;
        for (int c = 0; c < stop_col; c++) begin
            for (int b = 0; b < B; b++) begin
                in_valid = 1;
                for (int ln = 0; ln < L; ln++) begin
                    row = b*L + ln;
                    in_data[ln*DW +: DW] =
                        (row < N) ? img[row][c] : 16'($urandom);
                end
                kernel_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                kernel_data = 16'($urandom);
                n = 0;
                @(negedge clk);
                while (!in_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("in_ready_wait", in_ready, 1'b1);
                tick();
                in_valid = 0;
                kernel_valid = 0;
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_cnt != 0, 1'b1);
        repeat (3) tick();
    endtask

    task automatic clear_obs();
        q_col.delete();
        q_dat.delete();
        q2_col.delete();
        q2_dat.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_hs = -1;
    endtask

    task automatic check_job();
        chk("col_count", q_col.size(), OS);
        foreach (q_col[i]) begin
            chk("out_col", q_col[i], CW'(i));
            chk("out_data", q_dat[i], model_col(i, 1, OS));
        end
        chk("s2_count", q2_col.size(), OS2);
        foreach (q2_col[i]) begin
            chk("s2_col", q2_col[i], CW'(i));
            chk("s2_data", q2_dat[i], model_col(i, 2, OS2));
        end
        chk("done_count", done_cnt, 1);
        chk("done_timing", done_cyc, last_hs + 1);
        chk("busy_idle", busy, 1'b0);
        clear_obs();
    endtask

    task automatic run_job(input logic reuse, input logic relu,
                           input logic noise);
        start_job(reuse, relu);
        stream(N, noise);
        wait_done();
        check_job();
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_col", out_col, '0);
        repeat (3) tick();
        rst = 0;
        tick();

        set_identity();
        img_ramp();
        run_job(0, 0, 0);
        chk("ident_spot", q_dat.size(), 0);

        bp_rand = 1;
        run_job(1, 0, 1);

        for (int k = 0; k < K*K; k++)
            w_m[k] = 16'(int'($urandom_range(0, 1023)) - 512);
        b_m = 16'(int'($urandom_range(0, 1023)) - 512);
        img_rand();
        run_job(0, 1, 0);
        img_rand();
        run_job(1, 0, 1);

        for (int k = 0; k < K*K; k++) w_m[k] = 16'h7FFF;
        b_m = '0;
        img_const(16'h7FFF);
        run_job(0, 0, 0);
        img_const(16'h8000);
        run_job(1, 1, 0);
        run_job(1, 0, 0);

        bp_rand = 0;
        hold_arm = 1;
        set_identity();
        img_ramp();
        run_job(0, 0, 0);
        chk("hold_seen", hold_seen, 1'b1);

        bp_rand = 1;
        start_job(0, 0);
        stream(11, 0);
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("mid_in_ready", in_ready, 1'b0);
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_busy_clr", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_out_data", out_data, '0);
        chk("mid_out_col", out_col, '0);
        repeat (2) tick();
        chk("mid_no_done", done_cnt, 0);
        rst = 0;
        tick();
        clear_obs();

        img_rand();
        run_job(0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
